// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI serial-memory model.
// Holds the nibble type, the two supported SQI opcodes and the FSM state encoding.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } sqi_state_t;

endpackage

// File: rtl/idli_sqi_mem_m.sv
// Behavioural SQI (quad-SPI) serial memory: 2-nibble command, 24-bit address,
// 2 dummy nibbles on reads, unbounded streaming until chip select rises.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic      i_mem_gck,
  input  logic      i_mem_rst_n,
  input  logic      i_mem_sck,
  input  logic      i_mem_cs,
  input  sqi_data_t i_mem_sio,
  output sqi_data_t o_mem_sio,
  output logic      o_mem_sio_oe
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  sqi_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-5:0] shift_q, shift_d;
  logic              is_wr_q, is_wr_d;
  logic              half_q, half_d;     // 1: next data nibble is the low nibble
  sqi_data_t         wr_hi_q, wr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  sqi_data_t         sio_q, sio_d;
  logic              oe_q, oe_d;

  logic [ADDR_W-1:0] shift_in;
  logic [7:0]        rd_byte;
  logic              mem_we;
  logic [7:0]        mem_wdata;

  // Address bits above ADDR_W fall off the top of the shifter as they arrive.
  assign shift_in = {shift_q, i_mem_sio};
  assign rd_byte  = mem[addr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    is_wr_d   = is_wr_q;
    half_d    = half_q;
    wr_hi_d   = wr_hi_q;
    addr_d    = addr_q;
    sio_d     = sio_q;
    mem_we    = 1'b0;
    mem_wdata = {wr_hi_q, i_mem_sio};

    if (i_mem_cs) begin
      state_d = ST_CMD;
      cnt_d   = '0;
      half_d  = 1'b0;
    end else if (i_mem_sck) begin
      case (state_q)
        ST_CMD: begin
          shift_d = shift_in[ADDR_W-5:0];
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_d = '0;
            if (shift_in[7:0] == SQI_CMD_READ) begin
              state_d = ST_ADDR;
              is_wr_d = 1'b0;
            end else if (shift_in[7:0] == SQI_CMD_WRITE) begin
              state_d = ST_ADDR;
              is_wr_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          shift_d = shift_in[ADDR_W-5:0];
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            cnt_d   = '0;
            addr_d  = shift_in;
            half_d  = 1'b0;
            state_d = is_wr_q ? ST_WRITE : ST_DUMMY;
          end
        end
        ST_DUMMY: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            cnt_d   = '0;
            sio_d   = rd_byte[7:4];
            half_d  = 1'b1;
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          if (half_q) begin
            sio_d  = rd_byte[3:0];
            addr_d = addr_q + ADDR_ONE;
            half_d = 1'b0;
          end else begin
            sio_d  = rd_byte[7:4];
            half_d = 1'b1;
          end
        end
        ST_WRITE: begin
          if (half_q) begin
            mem_we = 1'b1;
            addr_d = addr_q + ADDR_ONE;
            half_d = 1'b0;
          end else begin
            wr_hi_d = i_mem_sio;
            half_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    oe_d = (state_d == ST_READ);
  end

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      state_q <= ST_CMD;
      cnt_q   <= '0;
      shift_q <= '0;
      is_wr_q <= 1'b0;
      half_q  <= 1'b0;
      wr_hi_q <= '0;
      addr_q  <= '0;
      sio_q   <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      is_wr_q <= is_wr_d;
      half_q  <= half_d;
      wr_hi_q <= wr_hi_d;
      addr_q  <= addr_d;
      sio_q   <= sio_d;
      oe_q    <= oe_d;
    end
  end

  // NOTE: the array has no reset; its contents survive rst_n and can be preloaded.
  always_ff @(posedge i_mem_gck) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
  end

  assign o_mem_sio    = sio_q;
  assign o_mem_sio_oe = oe_q;

endmodule
